// File: rtl/bj_redirect_unit_if.sv
// Bus between decode/execute, the redirect unit and the fetch PC mux.
// Handshakes: in_valid/in_ready and redir_valid/redir_ready each move one item on a rising edge where both are 1.
interface bj_redirect_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int INDEX_W   = 26,
    parameter int RAS_PTR_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  npc;
    logic [ADDR_W-1:0]  rd1;
    logic [ADDR_W-1:0]  extend_out;
    logic [INDEX_W-1:0] instr_index;
    logic [1:0]         bj_type;
    logic               br_taken;
    logic               link;
    logic               ret;
    logic               flush;
    logic               redir_valid;
    logic               redir_ready;
    logic [ADDR_W-1:0]  redir_pc;
    logic               redir_adel;
    logic [ADDR_W-1:0]  ras_top_pc;
    logic               ras_empty;
    logic [RAS_PTR_W:0] ras_count;

    modport master (
        output in_valid, npc, rd1, extend_out, instr_index, bj_type, br_taken,
               link, ret, flush, redir_ready,
        input  in_ready, redir_valid, redir_pc, redir_adel, ras_top_pc, ras_empty, ras_count
    );

    modport slave (
        input  in_valid, npc, rd1, extend_out, instr_index, bj_type, br_taken,
               link, ret, flush, redir_ready,
        output in_ready, redir_valid, redir_pc, redir_adel, ras_top_pc, ras_empty, ras_count
    );
endinterface

// File: rtl/bj_redirect_unit.sv
// Branch/jump target unit: registered redirect under valid/ready plus a circular return-address stack.
module bj_redirect_unit #(
    parameter int ADDR_W    = 32,
    parameter int INDEX_W   = 26,
    parameter int RAS_DEPTH = 8,
    parameter int RAS_PTR_W = 3
) (
    input  logic           clk,
    input  logic           resetn,
    bj_redirect_unit_if.slave bus
);
    localparam logic [1:0] BJ_J  = 2'd0;
    localparam logic [1:0] BJ_B  = 2'd1;
    localparam logic [1:0] BJ_JR = 2'd2;
    localparam logic [1:0] BJ_NOP = 2'd3;
    localparam logic [RAS_PTR_W:0] RAS_FULL = (RAS_PTR_W + 1)'(RAS_DEPTH);

    logic              accept;
    logic              taken;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] link_pc;

    logic              redir_valid_q;
    logic [ADDR_W-1:0] redir_pc_q;
    logic              redir_adel_q;

    logic [ADDR_W-1:0]    ras_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr;
    logic [RAS_PTR_W-1:0] ras_ptr_inc;
    logic [RAS_PTR_W-1:0] ras_ptr_dec;
    logic [RAS_PTR_W:0]   ras_count;

    assign bus.in_ready = ~bus.flush & (~redir_valid_q | bus.redir_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign link_pc      = bus.npc + ADDR_W'(4);

    always_comb begin
        target = bus.rd1;
        taken  = 1'b0;
        case (bus.bj_type)
            BJ_J: begin
                target = {bus.npc[ADDR_W-1:INDEX_W+2], bus.instr_index, 2'b00};
                taken  = 1'b1;
            end
            BJ_B: begin
                target = bus.npc + bus.extend_out;
                taken  = bus.br_taken;
            end
            BJ_JR: begin
                target = bus.rd1;
                taken  = 1'b1;
            end
            default: begin
                target = bus.rd1;
                taken  = 1'b0;
            end
        endcase
    end

    // Flush wins over everything; a new taken redirect may replace one being released this edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            redir_adel_q  <= 1'b0;
        end else if (bus.flush) begin
            redir_valid_q <= 1'b0;
        end else if (accept && taken) begin
            redir_valid_q <= 1'b1;
            redir_pc_q    <= target;
            redir_adel_q  <= (target[1:0] != 2'b00);
        end else if (bus.redir_ready) begin
            redir_valid_q <= 1'b0;
        end
    end

    assign do_push     = accept & (bus.bj_type != BJ_NOP) & bus.link;
    assign do_pop      = accept & (bus.bj_type != BJ_NOP) & bus.ret;
    assign ras_ptr_inc = ras_ptr + RAS_PTR_W'(1);
    assign ras_ptr_dec = ras_ptr - RAS_PTR_W'(1);

    // Push&pop on an empty stack has no top to replace, so it degrades to a plain push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ras_ptr   <= '0;
            ras_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (do_push && (!do_pop || ras_count == '0)) begin
            ras_ptr              <= ras_ptr_inc;
            ras_mem[ras_ptr_inc] <= link_pc;
            if (ras_count != RAS_FULL) ras_count <= ras_count + 1'b1;
        end else if (do_push) begin
            ras_mem[ras_ptr] <= link_pc;
        end else if (do_pop && ras_count != '0) begin
            ras_ptr   <= ras_ptr_dec;
            ras_count <= ras_count - 1'b1;
        end
    end

    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;
    assign bus.redir_adel  = redir_adel_q;
    assign bus.ras_top_pc  = (ras_count != '0) ? ras_mem[ras_ptr] : '0;
    assign bus.ras_empty   = (ras_count == '0);
    assign bus.ras_count   = ras_count;
endmodule
